spi_rom_arbiter: RTL and testbench

Shares one single-bit SPI flash ROM between two read requesters: port 0 for the VGA line fetch, at high priority, and port 1 for a secondary client such as a debug or CPU path. It grants one request at a time and runs a complete READ (03h) transaction for each grant: command, 24-bit address, then N data bytes. Received bytes are returned one per strobe, tagged with the source port. It sits between the display/fetch logic and the top-level SPI pad interface (`spi_cs`/`spi_sclk`/`spi_in`/`spi_out`/`spi_dir`).

---
 rtl/spi_rom_arbiter_if.sv | 26 ++
 rtl/spi_rom_arbiter.sv | 158 +++++++++++++++
 tb/tb_spi_rom_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_rom_arbiter_if.sv
// Request/return bus between the two read clients and spi_rom_arbiter.
// The arbiter uses the slave view; the clients (or a bench) use the master view.
interface spi_rom_arbiter_if;
  logic        req0_valid;
  logic [23:0] req0_addr;
  logic [7:0]  req0_len;
  logic        req0_ready;
  logic        req1_valid;
  logic [23:0] req1_addr;
  logic [7:0]  req1_len;
  logic        req1_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_src;
  logic        done;

  modport master (
    output req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len,
    input  req0_ready, req1_ready, rd_data, rd_valid, rd_src, done
  );

  modport slave (
    input  req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len,
    output req0_ready, req1_ready, rd_data, rd_valid, rd_src, done
  );
endinterface

// File: rtl/spi_rom_arbiter.sv
// Two-port arbiter sharing one single-bit SPI flash; runs a READ (cmd, 24-bit
// address, N bytes) per grant and returns bytes tagged with the owning port.
module spi_rom_arbiter #(
  parameter logic [7:0] CMD_READ   = 8'h03,
  parameter int         CS_GAP     = 2,
  parameter int         STARVE_MAX = 2
) (
  input  logic             clk,
  input  logic             reset,
  spi_rom_arbiter_if.slave bus,
  output logic             spi_cs,
  output logic             spi_sclk,
  input  logic [3:0]       spi_in,
  output logic [3:0]       spi_out,
  output logic [3:0]       spi_dir
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  bytes_q, bytes_d;
  logic        owner_q, owner_d;
  logic [7:0]  starve_q, starve_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_src_q, rd_src_d;
  logic        done_q, done_d;
  logic        cs_q, cs_d;
  logic        miso_q;
  logic        grant0, grant1, mosi;
  logic [7:0]  sel_len;
  logic        unused_pins;

  // Port 1 wins a tie only once port 0 has used up its starvation allowance.
  assign grant1 = bus.req1_valid && (!bus.req0_valid || (starve_q == STARVE_LIM));
  assign grant0 = bus.req0_valid && !grant1;

  assign bus.req0_ready = (state_q == IDLE) && grant0 && !reset;
  assign bus.req1_ready = (state_q == IDLE) && grant1 && !reset;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 8'd1;
    addr_d     = addr_q;
    bytes_d    = bytes_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    shift_d    = shift_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_src_d   = rd_src_q;
    done_d     = 1'b0;
    sel_len    = grant1 ? bus.req1_len : bus.req0_len;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (grant0 || grant1) begin
          state_d  = CMD;
          owner_d  = grant1;
          addr_d   = grant1 ? bus.req1_addr : bus.req0_addr;
          bytes_d  = (sel_len == 8'd0) ? 9'd256 : {1'b0, sel_len};
          starve_d = (grant0 && bus.req1_valid) ? starve_q + 8'd1 : 8'd0;
        end
      end
      CMD: begin
        if (cnt_q == 8'd7) state_d = ADDR;
      end
      ADDR: begin
        if (cnt_q == 8'd31) begin
          state_d = DATA;
          cnt_d   = 8'd0;
        end
      end
      DATA: begin
        // cnt_q[2:0] is the bit index inside the current byte.
        shift_d = {shift_q[5:0], miso_q};
        if (cnt_q[2:0] == 3'd7) begin
          rd_data_d  = {shift_q, miso_q};
          rd_valid_d = 1'b1;
          rd_src_d   = owner_q;
          bytes_d    = bytes_q - 9'd1;
          if (bytes_q == 9'd1) begin
            done_d  = 1'b1;
            state_d = GAP;
            cnt_d   = 8'd0;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cs_d = (state_d == CMD) || (state_d == ADDR) || (state_d == DATA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= 24'd0;
      bytes_q    <= 9'd0;
      owner_q    <= 1'b0;
      starve_q   <= 8'd0;
      shift_q    <= 7'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
      rd_src_q   <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      bytes_q    <= bytes_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      shift_q    <= shift_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_src_q   <= rd_src_d;
      done_q     <= done_d;
      cs_q       <= cs_d;
    end
  end

  // Falling clk is the rising SCLK edge, where the flash output is stable.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) miso_q <= 1'b0;
    else       miso_q <= spi_in[1];
  end

  always_comb begin
    mosi = 1'b0;
    case (state_q)
      CMD:     mosi = CMD_READ[~cnt_q[2:0]];
      ADDR:    mosi = addr_q[~cnt_q[4:0]];
      default: mosi = 1'b0;
    endcase
  end

  assign unused_pins  = ^{spi_in[3:2], spi_in[0]};
  assign spi_cs       = cs_q;
  assign spi_sclk     = ~clk;
  assign spi_out      = {3'b000, mosi};
  assign spi_dir      = 4'b1110;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_src   = rd_src_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_spi_rom_arbiter.sv
// Bench for spi_rom_arbiter: flash model on the pads, bus monitor, and a
// transaction-level scoreboard with an arbitration model.
module tb_spi_rom_arbiter;
  localparam int CS_GAP     = 2;
  localparam int STARVE_MAX = 2;

  typedef struct { logic port; logic [23:0] addr; logic [7:0] len; logic v0; logic v1; int cyc; } acc_rec_t;
  typedef struct { logic [7:0] data; logic src; logic done; int cyc; } rd_rec_t;
  typedef struct { logic [7:0] cmd; logic [23:0] addr; } hdr_t;
  typedef struct { logic port; logic [23:0] addr; logic [7:0] len; int exp_cs_hi; int exp_lat; } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] spi_in = 4'b0000;
  logic       spi_cs, spi_sclk;
  logic [3:0] spi_out, spi_dir;

  spi_rom_arbiter_if bus();

  spi_rom_arbiter #(.CMD_READ(8'h03), .CS_GAP(CS_GAP), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_in(spi_in),
    .spi_out(spi_out), .spi_dir(spi_dir)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;
  int m_starve = 0;
  int last_lat = -1;
  int both_ready = 0, r1_ready_cnt = 0, done_cnt = 0, stray_done = 0;
  acc_rec_t acc_q[$];
  rd_rec_t  rd_q[$];
  hdr_t     fl_q[$];
  int       cs_hi_q[$];
  int       cs_lo_q[$];

  function automatic logic [7:0] rom(input logic [23:0] a);
    if (a == 24'h000123) return 8'hA5;
    return 8'(a[7:0] * 8'd13) ^ a[15:8] ^ 8'(a[23:16] + 8'h5A);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Flash receive side: shift in command and address on rising SCLK.
  int   fk = 0;
  logic [31:0] fhdr = 32'd0;
  hdr_t fh;
  initial begin : flash_rx
    forever begin
      @(negedge clk);
      if (!spi_cs) fk = 0;
      else begin
        if (fk < 32) fhdr = {fhdr[30:0], spi_out[0]};
        fk++;
        if (fk == 32) begin
          fh.cmd = fhdr[31:24];
          fh.addr = fhdr[23:0];
          fl_q.push_back(fh);
        end
      end
    end
  end

  // Flash transmit side: bit j of the stream is presented in cycle 32+j.
  int         tx_j;
  logic [7:0] tx_b;
  initial begin : flash_tx
    forever begin
      @(posedge clk); #1;
      if (spi_cs && fk >= 32) begin
        tx_j = fk - 32;
        tx_b = rom(fhdr[23:0] + 24'(tx_j / 8));
        spi_in = {2'($urandom), tx_b[3'(7 - tx_j % 8)], 1'($urandom)};
      end
    end
  end

  acc_rec_t ma;
  rd_rec_t  mr;
  bit       cs_prev = 1'b0, seen_hi = 1'b0;
  int       hi_run = 0, lo_run = 0;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.req0_ready && bus.req1_ready) both_ready++;
      if (bus.req1_ready) r1_ready_cnt++;
      if (bus.req0_ready && bus.req0_valid) begin
        ma = '{1'b0, bus.req0_addr, bus.req0_len, bus.req0_valid, bus.req1_valid, cyc};
        acc_q.push_back(ma);
      end else if (bus.req1_ready && bus.req1_valid) begin
        ma = '{1'b1, bus.req1_addr, bus.req1_len, bus.req0_valid, bus.req1_valid, cyc};
        acc_q.push_back(ma);
      end
      if (bus.rd_valid) begin
        mr = '{bus.rd_data, bus.rd_src, bus.done, cyc};
        rd_q.push_back(mr);
      end
      if (bus.done) done_cnt++;
      if (bus.done && !bus.rd_valid) stray_done++;
      if (spi_cs) begin
        if (!cs_prev) begin
          if (seen_hi) cs_lo_q.push_back(lo_run);
          hi_run = 0;
        end
        hi_run++;
        seen_hi = 1'b1;
      end else begin
        if (cs_prev) begin
          cs_hi_q.push_back(hi_run);
          lo_run = 0;
        end
        lo_run++;
      end
      cs_prev = spi_cs;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    acc_q.delete(); rd_q.delete(); fl_q.delete(); cs_hi_q.delete(); cs_lo_q.delete();
  endtask

  task automatic set_req(input bit port, input bit v, input logic [23:0] a, input logic [7:0] l);
    if (port) begin bus.req1_valid = v; bus.req1_addr = a; bus.req1_len = l; end
    else      begin bus.req0_valid = v; bus.req0_addr = a; bus.req0_len = l; end
  endtask

  task automatic issue(input bit port, input logic [23:0] a, input logic [7:0] l, output int acc);
    tick();
    set_req(port, 1'b1, a, l);
    acc = -1;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (port ? bus.req1_ready : bus.req0_ready) begin acc = cyc; break; end
    end
    tick();
    set_req(port, 1'b0, a, l);
    if (acc < 0) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int bound);
    bit seen = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; break; end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    repeat (CS_GAP + 2) tick();
  endtask

  // Scoreboard: every logged grant must match the arbitration model and be
  // followed by its header on MOSI and exactly len ROM bytes at the right cycles.
  task automatic check_txns();
    acc_rec_t a;
    rd_rec_t  r;
    hdr_t     h;
    int       len_n, nb;
    logic     exp_port;
    while (acc_q.size() > 0) begin
      a = acc_q.pop_front();
      len_n = (a.len == 8'd0) ? 256 : int'(a.len);
      exp_port = a.v1 && (!a.v0 || m_starve == STARVE_MAX);
      check("grant_port", {31'd0, a.port}, {31'd0, exp_port});
      if (exp_port == 1'b0) m_starve = a.v1 ? m_starve + 1 : 0;
      else m_starve = 0;
      if (fl_q.size() == 0) check("hdr_present", 32'd0, 32'd1);
      else begin
        h = fl_q.pop_front();
        check("mosi_cmd", {24'd0, h.cmd}, 32'h03);
        check("mosi_addr", {8'd0, h.addr}, {8'd0, a.addr});
      end
      nb = 0;
      for (int i = 0; i < len_n; i++) begin
        if (rd_q.size() == 0) break;
        r = rd_q.pop_front();
        nb++;
        check("rd_data", {24'd0, r.data}, {24'd0, rom(a.addr + 24'(i))});
        check("rd_src", {31'd0, r.src}, {31'd0, a.port});
        check("done_flag", {31'd0, r.done}, (i == len_n - 1) ? 32'd1 : 32'd0);
        check("rd_cycle", r.cyc - a.cyc, 41 + 8 * i);
        last_lat = r.cyc - a.cyc;
      end
      check("byte_count", nb, len_n);
      $display("txn port=%0d addr=%06h len=%0d bytes=%0d", a.port, a.addr, len_n, nb);
    end
    check("extra_strobes", rd_q.size(), 0);
  endtask

  vec_t vecs[5];
  int   acc, n, quiet, base, base_done;
  int   exp_order[4];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 24'h000123, 8'd1, 40, 41};
    vecs[1] = '{1'b1, 24'h00FFFE, 8'd3, 56, 57};
    vecs[2] = '{1'b0, 24'hFFFFFF, 8'd2, 48, 49};
    vecs[3] = '{1'b1, 24'h012345, 8'd0, 2080, 2081};
    vecs[4] = '{1'b0, 24'hABCDEF, 8'd5, 72, 73};
    exp_order = '{0, 0, 1, 0};

    // Reset state, with both valids asserted to show readies are held low.
    set_req(1'b0, 1'b1, 24'h0, 8'd1);
    set_req(1'b1, 1'b1, 24'h0, 8'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", {31'd0, spi_cs}, 32'd0);
    check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    check("rst_rd_src", {31'd0, bus.rd_src}, 32'd0);
    check("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    check("spi_dir", {28'd0, spi_dir}, 32'hE);
    check("spi_out_idle", {28'd0, spi_out}, 32'h0);
    check("sclk_low_clk", {31'd0, spi_sclk}, 32'd1);
    tick();
    check("sclk_high_clk", {31'd0, spi_sclk}, 32'd0);
    set_req(1'b0, 1'b0, 24'h0, 8'd1);
    set_req(1'b1, 1'b0, 24'h0, 8'd1);
    reset = 1'b0;
    repeat (3) tick();
    clear_logs();

    // Table-driven single transactions.
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].port, vecs[i].addr, vecs[i].len, acc);
      wait_done(3000);
      if (i == 0) begin
        if (rd_q.size() > 0) check("rom_A5", {24'd0, rd_q[0].data}, 32'hA5);
        else check("rom_A5_present", 32'd0, 32'd1);
      end
      check_txns();
      check("done_latency", last_lat, vecs[i].exp_lat);
      if (cs_hi_q.size() > 0) check("cs_high_len", cs_hi_q[$], vecs[i].exp_cs_hi);
      else check("cs_high_present", 32'd0, 32'd1);
    end

    // Priority and starvation with both ports held valid.
    tick();
    set_req(1'b0, 1'b1, 24'h100000, 8'd2);
    set_req(1'b1, 1'b1, 24'h200000, 8'd2);
    n = 0;
    for (int k = 0; k < 2000 && n < 4; k++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) n++;
    end
    tick();
    set_req(1'b0, 1'b0, 24'h100000, 8'd2);
    set_req(1'b1, 1'b0, 24'h200000, 8'd2);
    check("prio_grants", n, 4);
    wait_done(500);
    for (int i = 0; i < 4; i++) begin
      if (acc_q.size() > i) check("prio_order", {31'd0, acc_q[i].port}, exp_order[i]);
      else check("prio_order_present", 32'd0, 32'd1);
    end
    check_txns();

    // Back-to-back port-0 requests: CS low for CS_GAP+1 between them.
    tick();
    set_req(1'b0, 1'b1, 24'h300000, 8'd1);
    n = 0;
    for (int k = 0; k < 1000 && n < 3; k++) begin
      @(negedge clk);
      if (bus.req0_ready) n++;
    end
    tick();
    set_req(1'b0, 1'b0, 24'h300000, 8'd1);
    wait_done(200);
    if (cs_lo_q.size() >= 3) begin
      check("b2b_gap1", cs_lo_q[cs_lo_q.size() - 2], CS_GAP + 1);
      check("b2b_gap2", cs_lo_q[cs_lo_q.size() - 1], CS_GAP + 1);
    end else check("b2b_gaps_present", cs_lo_q.size(), 3);
    check_txns();

    // Port-1 pulse during a port-0 DATA phase is never granted.
    base = r1_ready_cnt;
    issue(1'b0, 24'h400010, 8'd3, acc);
    for (int k = 0; k < 100 && cyc < acc + 36; k++) tick();
    set_req(1'b1, 1'b1, 24'h500000, 8'd1);
    repeat (6) tick();
    set_req(1'b1, 1'b0, 24'h500000, 8'd1);
    wait_done(200);
    check("busy_ready1", r1_ready_cnt - base, 0);
    check("busy_accepts", acc_q.size(), 1);
    check_txns();

    // Randomized traffic checked against the scoreboard and arbitration model.
    for (int k = 0; k < 3000; k++) begin
      tick();
      if ($urandom_range(0, 3) == 0)
        set_req(1'b0, 1'($urandom), 24'($urandom), 8'($urandom_range(1, 6)));
      if ($urandom_range(0, 3) == 0)
        set_req(1'b1, 1'($urandom), 24'($urandom), 8'($urandom_range(1, 6)));
    end
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    quiet = 0;
    for (int k = 0; k < 3000 && quiet < CS_GAP + 6; k++) begin
      @(negedge clk);
      if (spi_cs) quiet = 0; else quiet++;
    end
    check("rand_idle", (quiet >= CS_GAP + 6) ? 32'd1 : 32'd0, 32'd1);
    tick();
    check_txns();

    // Asynchronous reset in the middle of DATA (c=50) abandons the read.
    issue(1'b1, 24'h600000, 8'd4, acc);
    for (int k = 0; k < 100 && cyc < acc + 51; k++) tick();
    check("pre_rst_cs", {31'd0, spi_cs}, 32'd1);
    check("pre_rst_src", {31'd0, bus.rd_src}, 32'd1);
    base_done = done_cnt;
    #1 reset = 1'b1;
    #1;
    check("async_rst_cs", {31'd0, spi_cs}, 32'd0);
    check("async_rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("async_rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    check("async_rst_rd_src", {31'd0, bus.rd_src}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) tick();
    check("rst_no_done", done_cnt - base_done, 0);
    clear_logs();
    m_starve = 0;
    issue(1'b1, 24'h000123, 8'd2, acc);
    wait_done(300);
    check_txns();
    check("post_rst_latency", last_lat, 49);

    check("both_ready_total", both_ready, 0);
    check("stray_done", stray_done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
